// File: rtl/change_dispenser_if.sv
// Refund request, coin-ejector handshake and status bundle for change_dispenser.
// HEX2/HEX1/HEX0 exist only when CHANGE_DISP_HEX_EN is defined.
interface change_dispenser_if;
  logic       refund_req;
  logic [6:0] refund_amount;
  logic       coin_ack;
  logic       restock;
  logic       err_clr;
  logic       coin_valid;
  logic [2:0] coin_sel;
  logic       busy;
  logic       done;
  logic       error;
  logic [6:0] remaining;
  logic [2:0] low_stock;
`ifdef CHANGE_DISP_HEX_EN
  logic [7:0] HEX2;
  logic [7:0] HEX1;
  logic [7:0] HEX0;

  modport slave (
    input  refund_req, refund_amount, coin_ack, restock, err_clr,
    output coin_valid, coin_sel, busy, done, error, remaining, low_stock,
           HEX2, HEX1, HEX0
  );
  modport master (
    output refund_req, refund_amount, coin_ack, restock, err_clr,
    input  coin_valid, coin_sel, busy, done, error, remaining, low_stock,
           HEX2, HEX1, HEX0
  );
`else
  modport slave (
    input  refund_req, refund_amount, coin_ack, restock, err_clr,
    output coin_valid, coin_sel, busy, done, error, remaining, low_stock
  );
  modport master (
    output refund_req, refund_amount, coin_ack, restock, err_clr,
    input  coin_valid, coin_sel, busy, done, error, remaining, low_stock
  );
`endif
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays a cent amount as quarters/dimes/nickels, one coin per ejector ack.
// Optional decimal 7-seg display of the amount still owed under CHANGE_DISP_HEX_EN.
module change_dispenser #(
  parameter int unsigned Q_INIT     = 4,
  parameter int unsigned D_INIT     = 4,
  parameter int unsigned N_INIT     = 4,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned LOW_THRESH = 1
) (
  input  logic          clock,
  input  logic          resetn,
  change_dispenser_if.slave bus
);

  localparam int unsigned AMT_W = 7;
  localparam int unsigned SEL_W = 3;

  localparam logic [AMT_W-1:0] V_Q = AMT_W'(25);
  localparam logic [AMT_W-1:0] V_D = AMT_W'(10);
  localparam logic [AMT_W-1:0] V_N = AMT_W'(5);

  localparam logic [SEL_W-1:0] SEL_Q = 3'b100;
  localparam logic [SEL_W-1:0] SEL_D = 3'b010;
  localparam logic [SEL_W-1:0] SEL_N = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_EJECT  = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_coin_valid;
  logic [SEL_W-1:0]   r_coin_sel;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [AMT_W-1:0]   r_remaining;
  logic [STOCK_W-1:0] r_q;
  logic [STOCK_W-1:0] r_d;
  logic [STOCK_W-1:0] r_n;

  logic               w_pick_q;
  logic               w_pick_d;
  logic               w_pick_n;
  logic [AMT_W-1:0]   w_coin_val;

  // A coin is eligible only if it fits the amount owed and is in stock.
  assign w_pick_q = (r_remaining >= V_Q) && (r_q != '0);
  assign w_pick_d = (r_remaining >= V_D) && (r_d != '0);
  assign w_pick_n = (r_remaining >= V_N) && (r_n != '0);

  always_comb begin
    w_coin_val = '0;
    case (r_coin_sel)
      SEL_Q:   w_coin_val = V_Q;
      SEL_D:   w_coin_val = V_D;
      SEL_N:   w_coin_val = V_N;
      default: w_coin_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_coin_valid <= 1'b0;
      r_coin_sel   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_remaining  <= '0;
      r_q          <= STOCK_W'(Q_INIT);
      r_d          <= STOCK_W'(D_INIT);
      r_n          <= STOCK_W'(N_INIT);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.restock) begin
            r_q <= STOCK_W'(Q_INIT);
            r_d <= STOCK_W'(D_INIT);
            r_n <= STOCK_W'(N_INIT);
          end
          if (bus.refund_req) begin
            r_remaining <= bus.refund_amount;
            r_busy      <= 1'b1;
            r_state     <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (r_remaining == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_pick_q) begin
            r_coin_sel   <= SEL_Q;
            r_coin_valid <= 1'b1;
            r_state      <= S_EJECT;
          end else if (w_pick_d) begin
            r_coin_sel   <= SEL_D;
            r_coin_valid <= 1'b1;
            r_state      <= S_EJECT;
          end else if (w_pick_n) begin
            r_coin_sel   <= SEL_N;
            r_coin_valid <= 1'b1;
            r_state      <= S_EJECT;
          end else begin
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end
        end

        // Hold the coin request until the ejector takes it, then charge it off.
        S_EJECT: begin
          if (bus.coin_ack) begin
            r_remaining  <= r_remaining - w_coin_val;
            r_coin_valid <= 1'b0;
            r_coin_sel   <= '0;
            r_state      <= S_SELECT;
            case (r_coin_sel)
              SEL_Q:   if (r_q != '0) r_q <= r_q - STOCK_W'(1);
              SEL_D:   if (r_d != '0) r_d <= r_d - STOCK_W'(1);
              SEL_N:   if (r_n != '0) r_n <= r_n - STOCK_W'(1);
              default: ;
            endcase
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        S_ERROR: begin
          if (bus.restock) begin
            r_q <= STOCK_W'(Q_INIT);
            r_d <= STOCK_W'(D_INIT);
            r_n <= STOCK_W'(N_INIT);
          end
          if (bus.err_clr) begin
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
            r_remaining <= '0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_coin_valid <= 1'b0;
          r_coin_sel   <= '0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
          r_error      <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.coin_valid = r_coin_valid;
  assign bus.coin_sel   = r_coin_sel;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.remaining  = r_remaining;
  assign bus.low_stock  = {(r_q <= STOCK_W'(LOW_THRESH)),
                           (r_d <= STOCK_W'(LOW_THRESH)),
                           (r_n <= STOCK_W'(LOW_THRESH))};

`ifdef CHANGE_DISP_HEX_EN
  // Active-low {dp,g..a} segment pattern for one decimal digit, dp always off.
  function automatic logic [7:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 8'b11000000;
      4'd1:    seg7 = 8'b11111001;
      4'd2:    seg7 = 8'b10100100;
      4'd3:    seg7 = 8'b10110000;
      4'd4:    seg7 = 8'b10011001;
      4'd5:    seg7 = 8'b10010010;
      4'd6:    seg7 = 8'b10000010;
      4'd7:    seg7 = 8'b11111000;
      4'd8:    seg7 = 8'b10000000;
      4'd9:    seg7 = 8'b10010000;
      default: seg7 = 8'b11111111;
    endcase
  endfunction

  logic [AMT_W-1:0] w_hund;
  logic [AMT_W-1:0] w_tens;
  logic [AMT_W-1:0] w_ones;

  always_comb begin
    w_hund = r_remaining / AMT_W'(100);
    w_tens = (r_remaining / AMT_W'(10)) % AMT_W'(10);
    w_ones = r_remaining % AMT_W'(10);
  end

  assign bus.HEX2 = seg7(w_hund[3:0]);
  assign bus.HEX1 = seg7(w_tens[3:0]);
  assign bus.HEX0 = seg7(w_ones[3:0]);
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a greedy-payout reference model.
module tb_change_dispenser;

  logic clock = 1'b0;
  logic resetn;

  always #5 clock = ~clock;

  change_dispenser_if bus();

  change_dispenser dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference stock counts.
  int mq = 4;
  int md = 4;
  int mn = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_low();
    return {(mq <= 1), (md <= 1), (mn <= 1)};
  endfunction

`ifdef CHANGE_DISP_HEX_EN
  function automatic logic [7:0] seg_ref(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction
`endif

  task automatic clear_inputs();
    bus.refund_req    = 1'b0;
    bus.refund_amount = '0;
    bus.coin_ack      = 1'b0;
    bus.restock       = 1'b0;
    bus.err_clr       = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.coin_valid), 0);
    chk({tag, "_sel"},   32'(bus.coin_sel),   0);
    chk({tag, "_busy"},  32'(bus.busy),       0);
    chk({tag, "_done"},  32'(bus.done),       0);
    chk({tag, "_error"}, 32'(bus.error),      0);
    chk({tag, "_rem"},   32'(bus.remaining),  0);
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check_zero_outputs("reset");
    chk("reset_low", 32'(bus.low_stock), 0);
`ifdef CHANGE_DISP_HEX_EN
    chk("reset_hex2", 32'(bus.HEX2), 32'h C0);
    chk("reset_hex1", 32'(bus.HEX1), 32'h C0);
    chk("reset_hex0", 32'(bus.HEX0), 32'h C0);
`endif
    resetn = 1'b1;
    mq = 4; md = 4; mn = 4;
    @(negedge clock);
  endtask

  task automatic do_restock();
    bus.restock = 1'b1;
    @(negedge clock);
    bus.restock = 1'b0;
    mq = 4; md = 4; mn = 4;
    chk("restock_low", 32'(bus.low_stock), 0);
  endtask

  // hold < 0 picks a random ack delay per coin; hold >= 0 uses it and pokes ignored inputs.
  task automatic run_txn(input int amt, input int hold);
    int rem;
    int run;
    int w;
    int dly;
    int rs;
    logic [2:0] coins [$];
    logic [2:0] sel_seen;

    // Greedy payout from the specification: largest coin that fits and is stocked.
    rem = amt;
    while (rem > 0) begin
      if (rem >= 25 && mq > 0)      begin coins.push_back(3'b100); mq--; rem -= 25; end
      else if (rem >= 10 && md > 0) begin coins.push_back(3'b010); md--; rem -= 10; end
      else if (rem >= 5 && mn > 0)  begin coins.push_back(3'b001); mn--; rem -= 5;  end
      else break;
    end

    bus.refund_req    = 1'b1;
    bus.refund_amount = 7'(amt);
    @(negedge clock);
    bus.refund_req = 1'b0;
    chk("sel_busy", 32'(bus.busy), 1);
    chk("sel_rem", 32'(bus.remaining), 32'(amt));
    chk("sel_valid", 32'(bus.coin_valid), 0);
`ifdef CHANGE_DISP_HEX_EN
    chk("hex2", 32'(bus.HEX2), 32'(seg_ref(amt / 100)));
    chk("hex1", 32'(bus.HEX1), 32'(seg_ref((amt / 10) % 10)));
    chk("hex0", 32'(bus.HEX0), 32'(seg_ref(amt % 10)));
`endif

    run = amt;
    foreach (coins[i]) begin
      w = 0;
      while (!bus.coin_valid && w < 10) begin
        @(negedge clock);
        w++;
      end
      chk("coin_latency", 32'(w), 1);
      chk("coin_valid", 32'(bus.coin_valid), 1);
      if (!bus.coin_valid) return;
      chk("coin_sel", 32'(bus.coin_sel), 32'(coins[i]));
      sel_seen = bus.coin_sel;
      dly = (hold >= 0) ? hold : $urandom_range(0, 3);
      for (int k = 0; k < dly; k++) begin
        bus.restock       = 1'($urandom_range(0, 1));
        bus.refund_req    = (hold >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.refund_amount = 7'($urandom);
        bus.err_clr       = 1'($urandom_range(0, 1));
        @(negedge clock);
        chk("hold_valid", 32'(bus.coin_valid), 1);
        chk("hold_sel", 32'(bus.coin_sel), 32'(sel_seen));
        chk("hold_rem", 32'(bus.remaining), 32'(run));
      end
      clear_inputs();
      bus.coin_ack = 1'b1;
      @(negedge clock);
      bus.coin_ack = 1'b0;
      run -= (coins[i] == 3'b100) ? 25 : (coins[i] == 3'b010) ? 10 : 5;
      chk("ack_valid", 32'(bus.coin_valid), 0);
      chk("ack_rem", 32'(bus.remaining), 32'(run));
    end

    w = 0;
    while (!(bus.done || bus.error) && w < 10) begin
      @(negedge clock);
      w++;
    end
    chk("end_latency", 32'(w), 1);
    chk("end_valid", 32'(bus.coin_valid), 0);

    if (rem > 0) begin
      chk("err_flag", 32'(bus.error), 1);
      chk("err_done", 32'(bus.done), 0);
      chk("err_rem", 32'(bus.remaining), 32'(rem));
      chk("err_busy", 32'(bus.busy), 1);
      bus.coin_ack = 1'b1;
      @(negedge clock);
      bus.coin_ack = 1'b0;
      chk("err_hold", 32'(bus.error), 1);
      chk("err_hold_rem", 32'(bus.remaining), 32'(rem));
      rs = $urandom_range(0, 1);
      bus.restock = 1'(rs);
      bus.err_clr = 1'b1;
      @(negedge clock);
      clear_inputs();
      if (rs != 0) begin mq = 4; md = 4; mn = 4; end
      chk("clr_error", 32'(bus.error), 0);
      chk("clr_busy", 32'(bus.busy), 0);
      chk("clr_rem", 32'(bus.remaining), 0);
    end else begin
      chk("done_pulse", 32'(bus.done), 1);
      chk("done_rem", 32'(bus.remaining), 0);
      chk("done_error", 32'(bus.error), 0);
      @(negedge clock);
      chk("done_once", 32'(bus.done), 0);
      chk("done_busy", 32'(bus.busy), 0);
    end
    chk("low_stock", 32'(bus.low_stock), 32'(model_low()));
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    do_reset();

    // Directed scenarios.
    run_txn(40, 2);
    run_txn(7, -1);
    do_restock();
    run_txn(125, -1);
    chk("q_empty_low", 32'(bus.low_stock), 32'b100);
    do_restock();
    run_txn(0, -1);
    run_txn(30, 5);
    run_txn(127, -1);

    // Reset while a coin is in flight.
    bus.refund_req    = 1'b1;
    bus.refund_amount = 7'd40;
    @(negedge clock);
    bus.refund_req = 1'b0;
    @(negedge clock);
    chk("rst_pre_valid", 32'(bus.coin_valid), 1);
    #2 resetn = 1'b0;
    #1 check_zero_outputs("midrst");
    mq = 4; md = 4; mn = 4;
    chk("midrst_low", 32'(bus.low_stock), 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    run_txn(125, -1);
    chk("midrst_stock", 32'(bus.low_stock), 32'b100);

    // Randomized traffic with occasional restocks.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) do_restock();
      run_txn(int'($urandom_range(0, 127)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
